// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and frame layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    // Data bits, parity and stop; the start bit is driven during REQUEST.
    localparam int PS2_FRAME_BITS = 10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line, with synced level and falling-edge pulse.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shift frame on device clock, check line ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_CYCLES =
        (INHIBIT_CYCLES > REQ_CYCLES)
            ? ((INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES)
            : ((REQ_CYCLES > TIMEOUT_CYCLES) ? REQ_CYCLES : TIMEOUT_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    ps2_tx_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [9:0]    shift, shift_n;
    logic          ack_ok, ack_ok_n;
    logic          clock_oe_n, data_oe_n, done_n, error_n;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;
    logic timed;

    ps2_sync_edge u_clk_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_clock_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    // Handshake: a byte is taken on any cycle where tx_valid && tx_ready; tx_ready is high only in IDLE.
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign timed    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            ack_ok       <= 1'b0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            ack_ok       <= ack_ok_n;
            ps2_clock_oe <= clock_oe_n;
            ps2_data_oe  <= data_oe_n;
            tx_done      <= done_n;
            tx_error     <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        ack_ok_n   = ack_ok;
        clock_oe_n = ps2_clock_oe;
        data_oe_n  = ps2_data_oe;
        done_n     = 1'b0;
        error_n    = 1'b0;

        case (state)
            IDLE: begin
                clock_oe_n = 1'b0;
                data_oe_n  = 1'b0;
                if (tx_valid) begin
                    shift_n    = {1'b1, odd_parity(tx_data), tx_data};
                    cnt_n      = '0;
                    bit_cnt_n  = '0;
                    ack_ok_n   = 1'b0;
                    clock_oe_n = 1'b1;
                    state_n    = INHIBIT;
                end
            end
            INHIBIT: begin
                clock_oe_n = 1'b1;
                data_oe_n  = 1'b0;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = REQUEST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REQUEST: begin
                clock_oe_n = 1'b1;
                data_oe_n  = 1'b1;
                if (cnt == CW'(REQ_CYCLES - 1)) begin
                    cnt_n      = '0;
                    bit_cnt_n  = '0;
                    clock_oe_n = 1'b0;
                    state_n    = SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SEND: begin
                clock_oe_n = 1'b0;
                if (clk_fall) begin
                    data_oe_n = ~shift[bit_cnt];
                    bit_cnt_n = bit_cnt + 4'd1;
                    cnt_n     = '0;
                    if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_ok_n = ~data_level;
                    cnt_n    = '0;
                    state_n  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_n  = ack_ok;
                    error_n = ~ack_ok;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Device watchdog: only runs while the device owns the clock and nothing else happened.
        if (timed && !clk_fall && (state_n == state)) begin
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                cnt_n      = '0;
                clock_oe_n = 1'b0;
                data_oe_n  = 1'b0;
                error_n    = 1'b1;
                state_n    = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and frame scoreboard.
module tb_ps2_host_tx;

    localparam int T_INH = 20;
    localparam int T_REQ = 4;
    localparam int T_TO  = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clock_in, ps2_data_in;
    logic       ps2_clock_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_fall = 0;

    logic [9:0] exp_q[$];
    logic [1:0] out_q[$];

    // Wired-AND lines: either side can pull low.
    assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
    assign ps2_data_in  = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (T_INH),
        .REQ_CYCLES     (T_REQ),
        .TIMEOUT_CYCLES (T_TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (tx_valid && tx_ready) acc_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] make_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Present a byte, take it on the next edge, then check the inhibit/request shape.
    task automatic issue(input logic [7:0] d, input logic [1:0] outcome);
        int hi, rise, k;
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 100) begin
            step();
            k++;
        end
        step();
        tx_valid = 1'b0;
        exp_q.push_back(make_frame(d));
        out_q.push_back(outcome);
        chk("inhibit_start", {30'd0, busy, ps2_clock_oe}, 32'd3);
        hi = 0;
        rise = 0;
        k = 1;
        while (ps2_clock_oe && k < 1000) begin
            if (ps2_data_oe && rise == 0) rise = k;
            hi++;
            k++;
            step();
        end
        chk("clock_oe_high_cycles", hi, T_INH + T_REQ);
        chk("data_oe_rise_cycle", rise, T_INH + 1);
    endtask

    task automatic dev_xfer(input int n_falls, input bit nack, input int poke, input int rst_at);
        logic [9:0] frame;
        logic [9:0] expf;
        bit aborted;
        int k;
        frame = '0;
        aborted = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        k = 0;
        while (!(ps2_clock_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 2000) begin
            step();
            k++;
        end
        chk("request_seen", {31'd0, k < 2000}, 32'd1);
        repeat (10) step();
        for (int i = 0; i < n_falls; i++) begin
            if (i == 10) begin
                dev_data = nack;
                repeat (5) step();
            end
            dev_clk = 1'b0;
            last_fall = cyc;
            if (i == poke) begin
                tx_data = 8'h55;
                tx_valid = 1'b1;
                chk("holdoff_ready", {31'd0, tx_ready}, 32'd0);
                step();
                tx_valid = 1'b0;
            end
            if (i == rst_at) begin
                repeat (5) step();
                reset = 1'b1;
                #1;
                chk("reset_oe_async", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
                repeat (2) step();
                reset = 1'b0;
                dev_clk = 1'b1;
                aborted = 1'b1;
                break;
            end
            repeat (18) step();
            if (i < 10) frame[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            else repeat (20) step();
        end
        if (exp_q.size() > 0) begin
            expf = exp_q.pop_front();
            if (n_falls >= 10 && !aborted) chk("frame", {22'd0, frame}, {22'd0, expf});
        end
    endtask

    task automatic wait_result(input int bound, output logic [1:0] kind, output int at);
        kind = 2'd0;
        at = 0;
        for (int k = 0; k < bound; k++) begin
            step();
            if (tx_done || tx_error) begin
                kind = (tx_done && tx_error) ? 2'd3 : (tx_done ? 2'd1 : 2'd2);
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int bound);
        logic [1:0] kind, expk;
        int at;
        wait_result(bound, kind, at);
        expk = (out_q.size() > 0) ? out_q.pop_front() : 2'd3;
        chk(tag, {30'd0, kind}, {30'd0, expk});
    endtask

    task automatic check_no_extra(input string tag);
        logic [1:0] kind;
        int at;
        wait_result(50, kind, at);
        chk(tag, {30'd0, kind}, 32'd0);
    endtask

    initial begin
        logic [1:0] kind, expk;
        int at, a0;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) step();
        chk("reset_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        chk("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        chk("reset_busy_ready", {30'd0, busy, tx_ready}, 32'd1);
        reset = 1'b0;
        repeat (3) step();

        // Normal send of the set-LEDs command.
        issue(8'hED, 2'd1);
        dev_xfer(11, 1'b0, -1, -1);
        check_result("normal_result", 500);
        check_no_extra("normal_single_pulse");

        // Parity extremes.
        issue(8'h00, 2'd1);
        dev_xfer(11, 1'b0, -1, -1);
        check_result("zero_result", 500);
        issue(8'hFF, 2'd1);
        dev_xfer(11, 1'b0, -1, -1);
        check_result("ones_result", 500);

        // Device refuses the byte.
        issue(8'hED, 2'd2);
        dev_xfer(11, 1'b1, -1, -1);
        check_result("nack_result", 500);
        check_no_extra("nack_single_pulse");

        // Device stops clocking after four edges.
        issue(8'hED, 2'd2);
        dev_xfer(4, 1'b0, -1, -1);
        wait_result(1000, kind, at);
        expk = (out_q.size() > 0) ? out_q.pop_front() : 2'd3;
        chk("timeout_result", {30'd0, kind}, {30'd0, expk});
        chk("timeout_latency_in_range",
            {31'd0, ((at - last_fall) >= T_TO) && ((at - last_fall) <= T_TO + 5)}, 32'd1);
        step();
        chk("timeout_released", {29'd0, ps2_clock_oe, ps2_data_oe, tx_ready}, 32'd1);
        check_no_extra("timeout_single_pulse");

        // Request while busy is held off; next byte queued to go right after done.
        a0 = acc_cnt;
        issue(8'hED, 2'd1);
        dev_xfer(11, 1'b0, 3, -1);
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        check_result("holdoff_result", 500);
        issue(8'hF4, 2'd1);
        chk("accept_count", acc_cnt - a0, 2);
        dev_xfer(11, 1'b0, -1, -1);
        check_result("b2b_result", 500);
        check_no_extra("b2b_single_pulse");

        // Reset during bit 5, then a clean reset command.
        issue(8'hED, 2'd0);
        dev_xfer(11, 1'b0, -1, 5);
        check_result("reset_no_pulse", 300);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        issue(8'hFF, 2'd1);
        dev_xfer(11, 1'b0, -1, -1);
        check_result("after_reset_result", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
